dms_lock_detect: RTL and testbench

DMS_LOCK_DETECT -- requirements
Module: dms_lock_detect

---
 rtl/dms_lock_detect.sv | 162 ++++++++++++++++
 tb/tb_dms_lock_detect.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/dms_lock_detect.sv
// PFD activity lock detector: counts synchronized up/down activity per refclk
// window and runs a hysteretic lock FSM that is evaluated only on window close.
module dms_lock_detect #(
  parameter int unsigned WIN_LEN        = 256,
  parameter int unsigned ERR_THRESH     = 8,
  parameter int unsigned LOCK_WINDOWS   = 4,
  parameter int unsigned UNLOCK_WINDOWS = 2
) (
  input  logic                           refclk,
  input  logic                           rst_n,
  input  logic                           en,
  input  logic                           up,
  input  logic                           down,
  output logic                           lock,
  output logic [1:0]                     lock_state,
  output logic                           win_done,
  output logic [$clog2(WIN_LEN+1)-1:0]   err_last,
  output logic                           lock_lost
);

  localparam int unsigned CW = $clog2(WIN_LEN + 1);
  localparam int unsigned WW = $clog2(WIN_LEN);
  localparam int unsigned GW = $clog2(LOCK_WINDOWS + 1);
  localparam int unsigned BW = $clog2(UNLOCK_WINDOWS + 1);

  typedef enum logic [1:0] {
    UNLOCKED  = 2'd0,
    ACQUIRING = 2'd1,
    LOCKED    = 2'd2,
    SLIPPING  = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic          up_m, up_s, down_m, down_s;
  logic [WW-1:0] win_cnt;
  logic [CW-1:0] err_cnt, total;
  logic [GW-1:0] good_cnt, good_nxt, good_inc;
  logic [BW-1:0] bad_cnt, bad_nxt, bad_inc;
  logic          activity, close, good, lost_nxt;

  assign activity = up_s | down_s;
  assign close    = en && (win_cnt == WW'(WIN_LEN - 1));
  assign total    = err_cnt + CW'(activity);
  assign good     = 32'(total) <= ERR_THRESH;
  assign good_inc = good_cnt + 1'b1;
  assign bad_inc  = bad_cnt + 1'b1;

  // Synchronizer stays live while disabled so re-enable starts from clean samples.
  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      up_m   <= 1'b0;
      up_s   <= 1'b0;
      down_m <= 1'b0;
      down_s <= 1'b0;
    end else begin
      up_m   <= up;
      up_s   <= up_m;
      down_m <= down;
      down_s <= down_m;
    end
  end

  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      win_cnt  <= '0;
      err_cnt  <= '0;
      err_last <= '0;
      win_done <= 1'b0;
    end else if (!en) begin
      win_cnt  <= '0;
      err_cnt  <= '0;
      win_done <= 1'b0;
    end else begin
      win_done <= close;
      if (close) begin
        win_cnt  <= '0;
        err_cnt  <= '0;
        err_last <= total;
      end else begin
        win_cnt  <= win_cnt + 1'b1;
        err_cnt  <= total;
      end
    end
  end

  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      state     <= UNLOCKED;
      good_cnt  <= '0;
      bad_cnt   <= '0;
      lock_lost <= 1'b0;
    end else begin
      state     <= state_nxt;
      good_cnt  <= good_nxt;
      bad_cnt   <= bad_nxt;
      lock_lost <= lost_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    good_nxt  = good_cnt;
    bad_nxt   = bad_cnt;
    lost_nxt  = 1'b0;
    if (!en) begin
      state_nxt = UNLOCKED;
      good_nxt  = '0;
      bad_nxt   = '0;
    end else if (close) begin
      unique case (state)
        UNLOCKED: begin
          if (good) begin
            good_nxt  = GW'(1);
            state_nxt = (LOCK_WINDOWS == 1) ? LOCKED : ACQUIRING;
          end else begin
            good_nxt  = '0;
          end
        end
        ACQUIRING: begin
          if (good) begin
            good_nxt = good_inc;
            if (good_inc >= GW'(LOCK_WINDOWS)) state_nxt = LOCKED;
          end else begin
            good_nxt  = '0;
            state_nxt = UNLOCKED;
          end
        end
        LOCKED: begin
          if (!good) begin
            if (UNLOCK_WINDOWS == 1) begin
              state_nxt = UNLOCKED;
              lost_nxt  = 1'b1;
              good_nxt  = '0;
              bad_nxt   = '0;
            end else begin
              state_nxt = SLIPPING;
              bad_nxt   = BW'(1);
            end
          end
        end
        SLIPPING: begin
          if (good) begin
            state_nxt = LOCKED;
            bad_nxt   = '0;
          end else if (bad_inc >= BW'(UNLOCK_WINDOWS)) begin
            state_nxt = UNLOCKED;
            lost_nxt  = 1'b1;
            good_nxt  = '0;
            bad_nxt   = '0;
          end else begin
            bad_nxt   = bad_inc;
          end
        end
        default: state_nxt = UNLOCKED;
      endcase
    end
  end

  assign lock       = (state == LOCKED) || (state == SLIPPING);
  assign lock_state = state;

endmodule

// File: tb/tb_dms_lock_detect.sv
// Directed bench for dms_lock_detect with 16-cycle windows, threshold 2,
// 3 windows to lock and 2 windows to unlock.
module tb_dms_lock_detect;

  localparam int unsigned WIN = 16;
  localparam int unsigned CW  = $clog2(WIN + 1);

  logic          refclk = 1'b0;
  logic          rst_n, en, up, down;
  logic          lock, win_done, lock_lost;
  logic [1:0]    lock_state;
  logic [CW-1:0] err_last;

  int tests_run    = 0;
  int tests_failed = 0;
  int done_cnt;

  dms_lock_detect #(
    .WIN_LEN       (WIN),
    .ERR_THRESH    (2),
    .LOCK_WINDOWS  (3),
    .UNLOCK_WINDOWS(2)
  ) dut (
    .refclk    (refclk),
    .rst_n     (rst_n),
    .en        (en),
    .up        (up),
    .down      (down),
    .lock      (lock),
    .lock_state(lock_state),
    .win_done  (win_done),
    .err_last  (err_last),
    .lock_lost (lock_lost)
  );

  always #5 refclk = ~refclk;

  // Drive n cycles; cycle k carries up/down when a0 <= k < a0+alen.
  // A pulse driven in cycle k is counted by the DUT in cycle k+2.
  task automatic cycles(input int n, input int a0, input int alen,
                        input logic u, input logic d);
    done_cnt = 0;
    for (int k = 0; k < n; k++) begin
      up   = (k >= a0 && k < a0 + alen) ? u : 1'b0;
      down = (k >= a0 && k < a0 + alen) ? d : 1'b0;
      @(posedge refclk);
      #1;
      if (win_done) done_cnt++;
    end
    up   = 1'b0;
    down = 1'b0;
  endtask

  task automatic restart();
    en = 1'b0;
    cycles(3, 0, 0, 1'b0, 1'b0);
    en = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en    = 1'b0;
    cycles(3, 0, 0, 1'b0, 1'b0);
    tests_run++; if (lock !== 1'b0) begin tests_failed++; $display("FAIL reset_lock got %b exp 0", lock); end
    tests_run++; if (lock_state !== 2'd0) begin tests_failed++; $display("FAIL reset_state got %0d exp 0", lock_state); end
    tests_run++; if (win_done !== 1'b0) begin tests_failed++; $display("FAIL reset_win_done got %b exp 0", win_done); end
    tests_run++; if (lock_lost !== 1'b0) begin tests_failed++; $display("FAIL reset_lock_lost got %b exp 0", lock_lost); end
    tests_run++; if (err_last !== 5'd0) begin tests_failed++; $display("FAIL reset_err_last got %0d exp 0", err_last); end
    rst_n = 1'b1;
    cycles(2, 0, 0, 1'b0, 1'b0);
    tests_run++; if (done_cnt !== 0) begin tests_failed++; $display("FAIL disabled_no_done got %0d exp 0", done_cnt); end
  endtask

  task automatic test_quiet_lock();
    logic [1:0] exp_st [3];
    exp_st[0] = 2'd1; exp_st[1] = 2'd1; exp_st[2] = 2'd2;
    restart();
    for (int w = 0; w < 3; w++) begin
      cycles(15, 0, 0, 1'b0, 1'b0);
      tests_run++; if (done_cnt !== 0) begin tests_failed++; $display("FAIL quiet_early_done w%0d got %0d exp 0", w, done_cnt); end
      cycles(1, 0, 0, 1'b0, 1'b0);
      tests_run++; if (win_done !== 1'b1) begin tests_failed++; $display("FAIL quiet_win_done w%0d got %b exp 1", w, win_done); end
      tests_run++; if (lock_state !== exp_st[w]) begin tests_failed++; $display("FAIL quiet_state w%0d got %0d exp %0d", w, lock_state, exp_st[w]); end
      tests_run++; if (lock !== (w == 2)) begin tests_failed++; $display("FAIL quiet_lock w%0d got %b exp %b", w, lock, (w == 2)); end
      tests_run++; if (err_last !== 5'd0) begin tests_failed++; $display("FAIL quiet_err_last w%0d got %0d exp 0", w, err_last); end
    end
    cycles(1, 0, 0, 1'b0, 1'b0);
    tests_run++; if (win_done !== 1'b0) begin tests_failed++; $display("FAIL quiet_done_pulse got %b exp 0", win_done); end
  endtask

  task automatic test_threshold();
    int         act    [5];
    logic [1:0] exp_st [5];
    act[0] = 2; act[1] = 3; act[2] = 2; act[3] = 2; act[4] = 2;
    exp_st[0] = 2'd1; exp_st[1] = 2'd0; exp_st[2] = 2'd1; exp_st[3] = 2'd1; exp_st[4] = 2'd2;
    restart();
    for (int w = 0; w < 5; w++) begin
      cycles(16, 3, act[w], 1'b1, 1'b0);
      tests_run++; if (err_last !== 5'(act[w])) begin tests_failed++; $display("FAIL thr_err_last w%0d got %0d exp %0d", w, err_last, act[w]); end
      tests_run++; if (lock_state !== exp_st[w]) begin tests_failed++; $display("FAIL thr_state w%0d got %0d exp %0d", w, lock_state, exp_st[w]); end
      tests_run++; if (lock !== (w == 4)) begin tests_failed++; $display("FAIL thr_lock w%0d got %b exp %b", w, lock, (w == 4)); end
    end
  endtask

  task automatic test_slip_recover();
    cycles(16, 2, 10, 1'b0, 1'b1);
    tests_run++; if (err_last !== 5'd10) begin tests_failed++; $display("FAIL slip_err_last got %0d exp 10", err_last); end
    tests_run++; if (lock_state !== 2'd3) begin tests_failed++; $display("FAIL slip_state got %0d exp 3", lock_state); end
    tests_run++; if (lock !== 1'b1) begin tests_failed++; $display("FAIL slip_lock got %b exp 1", lock); end
    cycles(16, 0, 0, 1'b0, 1'b0);
    tests_run++; if (lock_state !== 2'd2) begin tests_failed++; $display("FAIL recover_state got %0d exp 2", lock_state); end
    tests_run++; if (lock_lost !== 1'b0) begin tests_failed++; $display("FAIL recover_lock_lost got %b exp 0", lock_lost); end
    tests_run++; if (lock !== 1'b1) begin tests_failed++; $display("FAIL recover_lock got %b exp 1", lock); end
  endtask

  task automatic test_loss();
    // Raise up two cycles before the window so both following windows see 16.
    cycles(16, 14, 2, 1'b1, 1'b0);
    tests_run++; if (lock_state !== 2'd2) begin tests_failed++; $display("FAIL loss_pre_state got %0d exp 2", lock_state); end
    cycles(16, 0, 16, 1'b1, 1'b0);
    tests_run++; if (err_last !== 5'd16) begin tests_failed++; $display("FAIL loss_err_last1 got %0d exp 16", err_last); end
    tests_run++; if (lock_state !== 2'd3) begin tests_failed++; $display("FAIL loss_state1 got %0d exp 3", lock_state); end
    tests_run++; if (lock_lost !== 1'b0) begin tests_failed++; $display("FAIL loss_lost1 got %b exp 0", lock_lost); end
    cycles(16, 0, 16, 1'b1, 1'b0);
    tests_run++; if (err_last !== 5'd16) begin tests_failed++; $display("FAIL loss_err_last2 got %0d exp 16", err_last); end
    tests_run++; if (lock_lost !== 1'b1) begin tests_failed++; $display("FAIL loss_lost2 got %b exp 1", lock_lost); end
    tests_run++; if (lock !== 1'b0) begin tests_failed++; $display("FAIL loss_lock got %b exp 0", lock); end
    tests_run++; if (lock_state !== 2'd0) begin tests_failed++; $display("FAIL loss_state2 got %0d exp 0", lock_state); end
    cycles(1, 0, 0, 1'b0, 1'b0);
    tests_run++; if (lock_lost !== 1'b0) begin tests_failed++; $display("FAIL loss_lost_pulse got %b exp 0", lock_lost); end
  endtask

  task automatic test_simultaneous();
    restart();
    cycles(16, 3, 4, 1'b1, 1'b1);
    tests_run++; if (err_last !== 5'd4) begin tests_failed++; $display("FAIL both_err_last got %0d exp 4", err_last); end
    tests_run++; if (lock_state !== 2'd0) begin tests_failed++; $display("FAIL both_state got %0d exp 0", lock_state); end
  endtask

  task automatic reach_slipping();
    restart();
    for (int w = 0; w < 3; w++) cycles(16, 0, 0, 1'b0, 1'b0);
    cycles(16, 2, 10, 1'b1, 1'b0);
  endtask

  task automatic test_disrupt_en();
    reach_slipping();
    tests_run++; if (lock_state !== 2'd3) begin tests_failed++; $display("FAIL den_pre_state got %0d exp 3", lock_state); end
    cycles(5, 0, 0, 1'b0, 1'b0);
    en = 1'b0;
    cycles(1, 0, 0, 1'b0, 1'b0);
    tests_run++; if (lock_state !== 2'd0) begin tests_failed++; $display("FAIL den_state got %0d exp 0", lock_state); end
    tests_run++; if (lock !== 1'b0) begin tests_failed++; $display("FAIL den_lock got %b exp 0", lock); end
    tests_run++; if (lock_lost !== 1'b0) begin tests_failed++; $display("FAIL den_lock_lost got %b exp 0", lock_lost); end
    cycles(4, 0, 4, 1'b1, 1'b0);
    tests_run++; if (err_last !== 5'd10) begin tests_failed++; $display("FAIL den_err_hold got %0d exp 10", err_last); end
    tests_run++; if (done_cnt !== 0) begin tests_failed++; $display("FAIL den_no_done got %0d exp 0", done_cnt); end
    cycles(3, 0, 0, 1'b0, 1'b0);
    en = 1'b1;
    cycles(15, 0, 0, 1'b0, 1'b0);
    tests_run++; if (done_cnt !== 0) begin tests_failed++; $display("FAIL den_early_done got %0d exp 0", done_cnt); end
    cycles(1, 0, 0, 1'b0, 1'b0);
    tests_run++; if (win_done !== 1'b1) begin tests_failed++; $display("FAIL den_first_done got %b exp 1", win_done); end
    tests_run++; if (lock_state !== 2'd1) begin tests_failed++; $display("FAIL den_post_state got %0d exp 1", lock_state); end
  endtask

  task automatic test_disrupt_rst();
    reach_slipping();
    // Bad window whose close edge coincides with reset.
    cycles(15, 0, 15, 1'b1, 1'b0);
    rst_n = 1'b0;
    cycles(1, 0, 1, 1'b1, 1'b0);
    tests_run++; if (lock_state !== 2'd0) begin tests_failed++; $display("FAIL drst_state got %0d exp 0", lock_state); end
    tests_run++; if (lock !== 1'b0) begin tests_failed++; $display("FAIL drst_lock got %b exp 0", lock); end
    tests_run++; if (lock_lost !== 1'b0) begin tests_failed++; $display("FAIL drst_lock_lost got %b exp 0", lock_lost); end
    tests_run++; if (win_done !== 1'b0) begin tests_failed++; $display("FAIL drst_win_done got %b exp 0", win_done); end
    tests_run++; if (err_last !== 5'd0) begin tests_failed++; $display("FAIL drst_err_last got %0d exp 0", err_last); end
    rst_n = 1'b1;
    cycles(15, 0, 0, 1'b0, 1'b0);
    tests_run++; if (done_cnt !== 0) begin tests_failed++; $display("FAIL drst_early_done got %0d exp 0", done_cnt); end
    cycles(1, 0, 0, 1'b0, 1'b0);
    tests_run++; if (win_done !== 1'b1) begin tests_failed++; $display("FAIL drst_first_done got %b exp 1", win_done); end
    tests_run++; if (err_last !== 5'd0) begin tests_failed++; $display("FAIL drst_post_err got %0d exp 0", err_last); end
    tests_run++; if (lock_state !== 2'd1) begin tests_failed++; $display("FAIL drst_post_state got %0d exp 1", lock_state); end
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    up    = 1'b0;
    down  = 1'b0;
    test_reset();
    test_quiet_lock();
    test_threshold();
    test_slip_recover();
    test_loss();
    test_simultaneous();
    test_disrupt_en();
    test_disrupt_rst();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
